id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  Decode->execute pipeline register and operand-select stage. Sits directly upstream of the ALU.
//  Latches the decoded instruction and resolves RAW hazards by forwarding.
//  Presents registered operands alu_a/alu_b and a 3-bit alu_op using the ADD..MUL codes in define.v.
//  Generates the load-use stall and inserts bubbles on stall or flush.
// PARAMETERS
//  DSIZE  `DSIZE  datapath width (define.v)
//  AW     5       register-address width; register 0 reads as zero and is never a forward target
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  id_valid    in   1      decode holds a valid instruction
//  id_op       in   3      ALU op code
//  id_rs1      in   AW     source register 1 address
//  id_rs2      in   AW     source register 2 address
//  id_rs1_data in   DSIZE  register-file read data 1
//  id_rs2_data in   DSIZE  register-file read data 2
//  id_imm      in   DSIZE  immediate
//  id_use_imm  in   1      1: operand b = imm; rs2 is not read
//  id_rd       in   AW     destination register
//  id_wen      in   1      instruction writes rd
//  id_is_load  in   1      instruction is a load; result arrives from MEM
//  flush       in   1      branch resolved taken; kill the decode-side instruction
//  alu_result  in   DSIZE  current ALU output (instruction held in this stage)
//  mem_rd      in   AW     MEM-stage destination register
//  mem_wen     in   1      MEM-stage write enable
//  mem_result  in   DSIZE  MEM-stage data
//  wb_rd       in   AW     WB-stage destination register
//  wb_wen      in   1      WB-stage write enable
//  wb_result   in   DSIZE  WB-stage data
//  stall       out  1      combinational; decode must hold its instruction
//  ex_valid    out  1      registered; alu_a/alu_b/alu_op are meaningful
//  alu_a       out  DSIZE  registered operand a
//  alu_b       out  DSIZE  registered operand b
//  alu_op      out  3      registered op code
//  ex_rd       out  AW     registered destination
//  ex_wen      out  1      registered write enable, forced 0 when ex_valid=0
//  ex_is_load  out  1      registered load flag, forced 0 when ex_valid=0
// BEHAVIOUR
//  - Reset (async): all outputs 0. alu_op = 0; the register holds a bubble.
//  - Match rule: a source rs matches stage X iff X_wen=1, X_rd==rs, and rs!=0. rs2 is ignored when id_use_imm=1.
//  - Forward priority per operand: EX (ex_valid, ex_wen, ex_rd; data alu_result) > MEM > WB > register file.
//  - Load-use stall: stall=1 when id_valid=1, ex_is_load=1, and an EX match exists.
//  - Each posedge, priority flush > stall > advance:
//      flush: load a bubble (ex_valid=0, ex_wen=0, ex_is_load=0); stall is forced to 0.
//      stall: load a bubble; decode holds; the instruction re-evaluates next cycle and then forwards from MEM.
//      advance: load id_* fields with resolved operands. ex_valid=id_valid.
//  - alu_b = id_use_imm ? id_imm : resolved rs2. Operands carry the full DSIZE width with no extension.
//  - Latency: one cycle from decode acceptance to operands at the ALU.
//  - Reset asserted mid-operation discards the held instruction immediately. No pending state survives reset.
//  - ex_rd/alu_* may hold stale values while ex_valid=0. ex_wen is always gated.
// CONFIGURATION
//  ID_EX_FWD_EN defined: forwarding as above; only load-use stalls.
//  ID_EX_FWD_EN undefined: no forward muxes; operands come from the register file only.
//    stall=1 while any EX, MEM, or WB match exists, so decode waits until the write has retired.
//    The WB compare is required because the register file writes at the clock edge with no write-through.
// TESTING
//  1 rst=1 mid-stream -> next sample: all outputs 0, stall=0; after release the first id_valid instruction appears 1 cycle later.
//  2 ADD r1,r2,r3 then ADD r4,r1,imm=5, alu_result=9, FWD_EN -> second op alu_a=9, alu_b=5, stall never 1.
//  3 Same rd in EX (alu_result=7) and MEM (mem_result=3), both wen -> alu_a=7. With rd=0: regfile data used.
//  4 Load r5 in EX, next instr reads r5 -> stall=1 for 1 cycle, bubble ex_valid=0, then alu_a=mem_result.
//  5 flush=1 together with stall=1 -> stall=0, next ex_valid=0, ex_wen=0.
//  6 FWD_EN undefined, back-to-back dependent ADDs -> stall held 3 cycles; operand = regfile value after WB.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with RAW hazard handling and operand select.
// Optional feature macro: ID_EX_FWD_EN (EX/MEM/WB forwarding; otherwise stall until retire).
`ifndef DSIZE
`define DSIZE 32
`endif

module id_ex_stage #(
  parameter int DSIZE = `DSIZE,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_op,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic [DSIZE-1:0] id_rs1_data,
  input  logic [DSIZE-1:0] id_rs2_data,
  input  logic [DSIZE-1:0] id_imm,
  input  logic             id_use_imm,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic [DSIZE-1:0] alu_result,
  input  logic [AW-1:0]    mem_rd,
  input  logic             mem_wen,
  input  logic [DSIZE-1:0] mem_result,
  input  logic [AW-1:0]    wb_rd,
  input  logic             wb_wen,
  input  logic [DSIZE-1:0] wb_result,
  output logic             stall,
  output logic             ex_valid,
  output logic [DSIZE-1:0] alu_a,
  output logic [DSIZE-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [AW-1:0]    ex_rd,
  output logic             ex_wen,
  output logic             ex_is_load
);

  logic             ex_valid_q, ex_valid_d;
  logic [DSIZE-1:0] alu_a_q, alu_a_d;
  logic [DSIZE-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [AW-1:0]    ex_rd_q, ex_rd_d;
  logic             ex_wen_q, ex_wen_d;
  logic             ex_is_load_q, ex_is_load_d;

  logic             rs2_used;
  logic             ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic             stall_raw;
  logic [DSIZE-1:0] op_a, op_b;

  // Register 0 is hardwired to zero, so it never depends on an older writer.
  function automatic logic src_match(input logic wen, input logic [AW-1:0] rd,
                                     input logic [AW-1:0] rs);
    return wen && (rd == rs) && (rs != '0);
  endfunction

  assign rs2_used = ~id_use_imm;

  assign ex_m1  = src_match(ex_valid_q & ex_wen_q, ex_rd_q, id_rs1);
  assign ex_m2  = rs2_used & src_match(ex_valid_q & ex_wen_q, ex_rd_q, id_rs2);
  assign mem_m1 = src_match(mem_wen, mem_rd, id_rs1);
  assign mem_m2 = rs2_used & src_match(mem_wen, mem_rd, id_rs2);
  assign wb_m1  = src_match(wb_wen, wb_rd, id_rs1);
  assign wb_m2  = rs2_used & src_match(wb_wen, wb_rd, id_rs2);

`ifdef ID_EX_FWD_EN
  // Only a load in EX cannot be forwarded: its data exists one stage later.
  assign stall_raw = id_valid & ex_is_load_q & (ex_m1 | ex_m2);

  always_comb begin
    op_a = id_rs1_data;
    if (ex_m1)       op_a = alu_result;
    else if (mem_m1) op_a = mem_result;
    else if (wb_m1)  op_a = wb_result;

    op_b = id_rs2_data;
    if (id_use_imm)  op_b = id_imm;
    else if (ex_m2)  op_b = alu_result;
    else if (mem_m2) op_b = mem_result;
    else if (wb_m2)  op_b = wb_result;
  end
`else
  // The register file has no write-through, so a WB writer also blocks the read.
  assign stall_raw = id_valid & (ex_m1 | ex_m2 | mem_m1 | mem_m2 | wb_m1 | wb_m2);

  always_comb begin
    op_a = id_rs1_data;
    op_b = id_use_imm ? id_imm : id_rs2_data;
  end

  logic unused_fwd_data;
  assign unused_fwd_data = ^{alu_result, mem_result, wb_result};
`endif

  assign stall = stall_raw & ~flush;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    ex_rd_d      = ex_rd_q;
    ex_wen_d     = ex_wen_q;
    ex_is_load_d = ex_is_load_q;
    if (flush || stall_raw) begin
      ex_valid_d   = 1'b0;
      ex_wen_d     = 1'b0;
      ex_is_load_d = 1'b0;
    end else begin
      ex_valid_d   = id_valid;
      alu_a_d      = op_a;
      alu_b_d      = op_b;
      alu_op_d     = id_op;
      ex_rd_d      = id_rd;
      ex_wen_d     = id_valid & id_wen;
      ex_is_load_d = id_valid & id_is_load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 3'd0;
      ex_rd_q      <= '0;
      ex_wen_q     <= 1'b0;
      ex_is_load_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      ex_rd_q      <= ex_rd_d;
      ex_wen_q     <= ex_wen_d;
      ex_is_load_q <= ex_is_load_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign ex_rd      = ex_rd_q;
  assign ex_wen     = ex_wen_q;
  assign ex_is_load = ex_is_load_q;

endmodule
